im_load_ctrl: RTL and testbench

// - Sequencer/arbiter for the 256-word instruction memory shared by CPU fetch and a byte-stream program loader.
// - IDLE: CPU fetch address passes straight through to the IM read port.
// - Load session: CPU is stalled and fed NOP words. Incoming bytes are packed big-endian into
//   32-bit words, each written at base+n.
// - Sits between PC/fetch logic and the IM array; replaces hard-coded initial program images.

---
 rtl/im_load_ctrl.sv | 173 +++++++++++++++++
 tb/tb_im_load_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_load_ctrl.sv
// Instruction-memory load sequencer: passes CPU fetches through when idle and packs loader bytes into IM words.
// Optional end-of-session checksum byte enabled by defining IM_LOAD_CHECKSUM_EN.
module im_load_ctrl #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_start,
    input  logic [ADDR_W-1:0] i_load_base,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    input  logic [31:0]       i_cpu_addr,
    output logic [31:0]       o_cpu_data,
    output logic              o_cpu_stall,
    output logic [ADDR_W-1:0] o_im_raddr,
    input  logic [31:0]       i_im_rdata,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_waddr,
    output logic [31:0]       o_im_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

`ifdef IM_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_word_cnt;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;
    logic              r_byte_ready;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_waddr;
    logic [31:0]       r_im_wdata;
    logic              r_busy;
    logic              r_done;
    logic              w_xfer;
    logic              w_last_word;
    logic              w_unused_addr;

`ifdef IM_LOAD_CHECKSUM_EN
    logic [7:0]        r_sum;
    logic              r_err;

    function automatic logic [7:0] f_sum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction
`endif

    assign w_xfer        = i_byte_valid && r_byte_ready;
    assign w_last_word   = (r_word_cnt == (r_len - (ADDR_W+1)'(1)));
    assign w_unused_addr = ^{i_cpu_addr[31:ADDR_W+2], i_cpu_addr[1:0]};

    assign o_im_raddr   = i_cpu_addr[ADDR_W+1:2];
    assign o_cpu_data   = r_busy ? NOP_WORD : i_im_rdata;
    assign o_cpu_stall  = r_busy;
    assign o_byte_ready = r_byte_ready;
    assign o_im_we      = r_im_we;
    assign o_im_waddr   = r_im_waddr;
    assign o_im_wdata   = r_im_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
`ifdef IM_LOAD_CHECKSUM_EN
    assign o_err        = r_err;
`else
    assign o_err        = 1'b0;
`endif

    // Session FSM with all handshake and IM write outputs registered
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_byte_cnt   <= 2'd0;
            r_word       <= 24'd0;
            r_byte_ready <= 1'b0;
            r_im_we      <= 1'b0;
            r_im_waddr   <= '0;
            r_im_wdata   <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef IM_LOAD_CHECKSUM_EN
            r_sum        <= 8'd0;
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A zero-length request never opens a session
                    if (i_load_start && (i_load_len != '0)) begin
                        r_state      <= S_COLLECT;
                        r_base       <= i_load_base;
                        r_len        <= i_load_len;
                        r_word_cnt   <= '0;
                        r_byte_cnt   <= 2'd0;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
`ifdef IM_LOAD_CHECKSUM_EN
                        r_sum        <= 8'd0;
                        r_err        <= 1'b0;
`endif
                    end
                end
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_word     <= {r_word[15:0], i_byte_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IM_LOAD_CHECKSUM_EN
                        r_sum      <= f_sum_add(r_sum, i_byte_data);
`endif
                        if (r_byte_cnt == 2'd3) begin
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_im_we      <= 1'b1;
                            r_im_waddr   <= r_base + r_word_cnt[ADDR_W-1:0];
                            r_im_wdata   <= {r_word, i_byte_data};
                        end
                    end
                end
                S_WRITE: begin
                    r_im_we <= 1'b0;
                    if (w_last_word) begin
`ifdef IM_LOAD_CHECKSUM_EN
                        r_state      <= S_CHECK;
                        r_byte_ready <= 1'b1;
`else
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
`endif
                    end else begin
                        r_state      <= S_COLLECT;
                        r_word_cnt   <= r_word_cnt + (ADDR_W+1)'(1);
                        r_byte_ready <= 1'b1;
                    end
                end
`ifdef IM_LOAD_CHECKSUM_EN
                S_CHECK: begin
                    if (w_xfer) begin
                        r_err        <= (i_byte_data != r_sum);
                        r_byte_ready <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b0;
                    r_im_we      <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_load_ctrl.sv
// Directed self-checking bench for im_load_ctrl (default build; checksum scenarios with IM_LOAD_CHECKSUM_EN).
module tb_im_load_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] RD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        i_rst_n, i_load_start, i_byte_valid;
    logic [7:0]  i_load_base, i_byte_data;
    logic [8:0]  i_load_len;
    logic [31:0] i_cpu_addr, i_im_rdata;
    logic        o_byte_ready, o_cpu_stall, o_im_we, o_busy, o_done, o_err;
    logic [31:0] o_cpu_data, o_im_wdata;
    logic [7:0]  o_im_raddr, o_im_waddr;

    int errors = 0;
    int checks = 0;

    logic [7:0]  bytes_q [0:15];
    logic [7:0]  wr_addr [0:7];
    logic [31:0] wr_data [0:7];
    int nwr, done_cnt, nop_bad, stall_bad, last_acc, wr_cyc, done_cyc, idx;

    always #5 clk = ~clk;

    im_load_ctrl dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_load_start(i_load_start),
        .i_load_base(i_load_base), .i_load_len(i_load_len),
        .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data), .o_byte_ready(o_byte_ready),
        .i_cpu_addr(i_cpu_addr), .o_cpu_data(o_cpu_data), .o_cpu_stall(o_cpu_stall),
        .o_im_raddr(o_im_raddr), .i_im_rdata(i_im_rdata), .o_im_we(o_im_we),
        .o_im_waddr(o_im_waddr), .o_im_wdata(o_im_wdata), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a session and feeds bytes_q; cycle c's observation is taken after the edge ending cycle c.
    task automatic run_load(input logic [7:0] base, input logic [8:0] len, input int nbytes,
                            input int gap, input int pulse_mid, input int stop_at);
        logic xfer;
        nwr = 0; done_cnt = 0; nop_bad = 0; stall_bad = 0; idx = 0;
        last_acc = -1; wr_cyc = -1; done_cyc = -1;
        i_load_base = base; i_load_len = len; i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            i_byte_valid = (idx < nbytes) && ((gap == 0) || (cyc % 2 == 0));
            i_byte_data  = bytes_q[idx];
            if (pulse_mid != 0 && cyc == 5) begin
                i_load_start = 1'b1;
                i_load_base  = 8'h77;
            end else begin
                i_load_start = 1'b0;
            end
            xfer = i_byte_valid && o_byte_ready;
            tick();
            if (xfer) begin
                idx++;
                last_acc = cyc;
            end
            if (o_im_we) begin
                if (nwr < 8) begin
                    wr_addr[nwr] = o_im_waddr;
                    wr_data[nwr] = o_im_wdata;
                end
                nwr++;
                wr_cyc = cyc + 1;
            end
            if (o_busy && o_cpu_data !== NOP) nop_bad++;
            if (o_cpu_stall !== o_busy) stall_bad++;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc + 1;
            end
            if (stop_at > 0 && idx == stop_at) break;
            if (!o_busy) break;
        end
        i_byte_valid = 1'b0;
        i_load_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_load_start = 1'b1; i_load_len = 9'd1; i_load_base = 8'd3;
        i_byte_valid = 1'b1; i_byte_data = 8'h5A; i_cpu_addr = 32'h0; i_im_rdata = RD;
        tick(); tick();
        checks++; if ({o_busy, o_byte_ready, o_im_we, o_done, o_err, o_cpu_stall} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                               {o_busy, o_byte_ready, o_im_we, o_done, o_err, o_cpu_stall});
        end
        checks++; if ({o_im_waddr, o_im_wdata} !== 40'd0) begin
            errors++; $display("FAIL reset_wr: got %h/%h expected 00/00000000", o_im_waddr, o_im_wdata);
        end
        i_load_start = 1'b0; i_byte_valid = 1'b0; i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        logic we_seen;
        we_seen = 1'b0;
        i_cpu_addr = 32'h0000_00A8; i_im_rdata = RD;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (o_im_we) we_seen = 1'b1;
        end
        checks++; if (o_im_raddr !== 8'd42) begin
            errors++; $display("FAIL pass_raddr: got %0d expected 42", o_im_raddr);
        end
        checks++; if (o_cpu_data !== RD) begin
            errors++; $display("FAIL pass_data: got %h expected %h", o_cpu_data, RD);
        end
        checks++; if ({we_seen, o_cpu_stall} !== 2'b00) begin
            errors++; $display("FAIL pass_idle: got we/stall %b expected 00", {we_seen, o_cpu_stall});
        end
    endtask

    task automatic test_load();
        int nb;
        bytes_q[0] = 8'h20; bytes_q[1] = 8'h08; bytes_q[2] = 8'h00; bytes_q[3] = 8'h07;
        bytes_q[4] = 8'h20; bytes_q[5] = 8'h09; bytes_q[6] = 8'h00; bytes_q[7] = 8'h08;
        bytes_q[8] = 8'h60;
        nb = 8;
`ifdef IM_LOAD_CHECKSUM_EN
        nb = 9;
`endif
        run_load(8'd40, 9'd2, nb, 0, 0, 0);
        checks++; if (nwr !== 2) begin
            errors++; $display("FAIL load_nwr: got %0d expected 2", nwr);
        end
        checks++; if ({wr_addr[0], wr_data[0]} !== {8'd40, 32'h2008_0007}) begin
            errors++; $display("FAIL load_w0: got %0d/%h expected 40/20080007", wr_addr[0], wr_data[0]);
        end
        checks++; if ({wr_addr[1], wr_data[1]} !== {8'd41, 32'h2009_0008}) begin
            errors++; $display("FAIL load_w1: got %0d/%h expected 41/20090008", wr_addr[1], wr_data[1]);
        end
        checks++; if (done_cnt !== 1) begin
            errors++; $display("FAIL load_done: got %0d pulses expected 1", done_cnt);
        end
        checks++; if ({nop_bad, stall_bad} !== 64'd0) begin
            errors++; $display("FAIL load_nop: got %0d/%0d bad cycles expected 0/0", nop_bad, stall_bad);
        end
`ifdef IM_LOAD_CHECKSUM_EN
        checks++; if (done_cyc !== last_acc + 1) begin
            errors++; $display("FAIL load_lat: got done@%0d expected %0d", done_cyc, last_acc + 1);
        end
`else
        checks++; if ({wr_cyc, done_cyc} !== {last_acc + 1, last_acc + 2}) begin
            errors++; $display("FAIL load_lat: got we@%0d done@%0d expected %0d/%0d",
                               wr_cyc, done_cyc, last_acc + 1, last_acc + 2);
        end
`endif
        checks++; if (o_err !== 1'b0) begin
            errors++; $display("FAIL load_err: got %b expected 0", o_err);
        end
    endtask

    task automatic test_wrap_gaps();
        int nb;
        bytes_q[0] = 8'h11; bytes_q[1] = 8'h22; bytes_q[2] = 8'h33; bytes_q[3] = 8'h44;
        bytes_q[4] = 8'h55; bytes_q[5] = 8'h66; bytes_q[6] = 8'h77; bytes_q[7] = 8'h88;
        bytes_q[8] = 8'h42;
        nb = 8;
`ifdef IM_LOAD_CHECKSUM_EN
        nb = 9;
`endif
        run_load(8'd255, 9'd2, nb, 1, 1, 0);
        checks++; if (nwr !== 2) begin
            errors++; $display("FAIL wrap_nwr: got %0d expected 2", nwr);
        end
        checks++; if ({wr_addr[0], wr_data[0]} !== {8'd255, 32'h1122_3344}) begin
            errors++; $display("FAIL wrap_w0: got %0d/%h expected 255/11223344", wr_addr[0], wr_data[0]);
        end
        checks++; if ({wr_addr[1], wr_data[1]} !== {8'd0, 32'h5566_7788}) begin
            errors++; $display("FAIL wrap_w1: got %0d/%h expected 0/55667788", wr_addr[1], wr_data[1]);
        end
        checks++; if ({done_cnt, nop_bad} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL wrap_done: got done=%0d nop_bad=%0d expected 1/0", done_cnt, nop_bad);
        end
    endtask

    task automatic test_abort();
        int nb;
        for (int k = 0; k < 8; k++) bytes_q[k] = 8'(k + 1);
        run_load(8'd10, 9'd2, 8, 0, 0, 5);
        i_rst_n = 1'b0;
        tick();
        checks++; if ({o_busy, o_byte_ready, o_im_we, o_done} !== 4'b0) begin
            errors++; $display("FAIL abort_idle: got %b expected 0000", {o_busy, o_byte_ready, o_im_we, o_done});
        end
        tick();
        i_rst_n = 1'b1;
        tick();
        checks++; if ({o_busy, o_done, o_im_waddr, o_im_wdata} !== 42'd0) begin
            errors++; $display("FAIL abort_after: got busy=%b done=%b wr=%h/%h expected all 0",
                               o_busy, o_done, o_im_waddr, o_im_wdata);
        end
        checks++; if ({nwr, done_cnt} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL abort_count: got writes=%0d done=%0d expected 1/0", nwr, done_cnt);
        end
        checks++; if ({wr_addr[0], wr_data[0]} !== {8'd10, 32'h0102_0304}) begin
            errors++; $display("FAIL abort_w0: got %0d/%h expected 10/01020304", wr_addr[0], wr_data[0]);
        end
        // The partial word from the aborted session must not leak into the next one
        bytes_q[0] = 8'hAA; bytes_q[1] = 8'hBB; bytes_q[2] = 8'hCC; bytes_q[3] = 8'hDD;
        bytes_q[4] = 8'h0E;
        nb = 4;
`ifdef IM_LOAD_CHECKSUM_EN
        nb = 5;
`endif
        run_load(8'd20, 9'd1, nb, 0, 0, 0);
        checks++; if ({nwr, done_cnt} !== {32'd1, 32'd1}) begin
            errors++; $display("FAIL fresh_count: got writes=%0d done=%0d expected 1/1", nwr, done_cnt);
        end
        checks++; if ({wr_addr[0], wr_data[0]} !== {8'd20, 32'hAABB_CCDD}) begin
            errors++; $display("FAIL fresh_w0: got %0d/%h expected 20/AABBCCDD", wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_len_zero();
        i_load_base = 8'd7; i_load_len = 9'd0; i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        checks++; if ({o_busy, o_byte_ready} !== 2'b00) begin
            errors++; $display("FAIL len0_busy: got busy/ready %b expected 00", {o_busy, o_byte_ready});
        end
        tick();
        checks++; if ({o_done, o_im_we} !== 2'b00) begin
            errors++; $display("FAIL len0_done: got done/we %b expected 00", {o_done, o_im_we});
        end
    endtask

`ifdef IM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        bytes_q[0] = 8'h01; bytes_q[1] = 8'h02; bytes_q[2] = 8'h03; bytes_q[3] = 8'h04;
        bytes_q[4] = 8'h0A;
        run_load(8'd5, 9'd1, 5, 0, 0, 0);
        checks++; if ({o_err, done_cnt} !== {1'b0, 32'd1}) begin
            errors++; $display("FAIL csum_good: got err=%b done=%0d expected 0/1", o_err, done_cnt);
        end
        bytes_q[4] = 8'h0B;
        run_load(8'd5, 9'd1, 5, 0, 0, 0);
        tick(); tick();
        checks++; if (o_err !== 1'b1) begin
            errors++; $display("FAIL csum_bad: got err=%b expected 1", o_err);
        end
        i_load_len = 9'd1; i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        checks++; if ({o_err, o_busy} !== 2'b01) begin
            errors++; $display("FAIL csum_clear: got err/busy %b expected 01", {o_err, o_busy});
        end
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        i_rst_n = 1'b0; i_load_start = 1'b0; i_load_base = 8'd0; i_load_len = 9'd0;
        i_byte_valid = 1'b0; i_byte_data = 8'd0; i_cpu_addr = 32'd0; i_im_rdata = RD;
        for (int k = 0; k < 16; k++) bytes_q[k] = 8'd0;
        test_reset();
        test_passthrough();
        test_load();
        test_wrap_gaps();
        test_abort();
        test_len_zero();
`ifdef IM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
